// File: rtl/id_decode_queue.sv
// Decode stage: DEPTH-entry fetch queue feeding one registered decode slot, with a
// one-bubble load-use interlock and flush. Define ID_ILLEGAL_TRAP_EN to flag illegal encodings.
module id_decode_queue #(
    parameter  int XLEN  = 64,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [31:0]      if_inst,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_pc,
    output logic [31:0]      id_inst,
    output logic [4:0]       id_rs1_addr,
    output logic [4:0]       id_rs2_addr,
    output logic [4:0]       id_rd_addr,
    output logic             id_rs1_ena,
    output logic             id_rs2_ena,
    output logic             id_rd_ena,
    output logic             id_is_load,
    output logic [2:0]       id_fmt,
    output logic [XLEN-1:0]  id_imm,
    output logic             id_illegal,
    output logic [CNT_W-1:0] iq_count
);
    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_IMM32  = 7'b0011011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS, FMT_UNK
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } iq_entry_t;

    typedef struct packed {
        logic            rs1_ena;
        logic            rs2_ena;
        logic            rd_ena;
        logic            is_load;
        logic            illegal;
        fmt_e            fmt;
        logic [XLEN-1:0] imm;
    } dec_t;

    iq_entry_t        mem [DEPTH];
    iq_entry_t        head;
    dec_t             dec;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, load, hazard;
    logic [6:0]       opc;
    logic [4:0]       rs1, rs2, rd;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;

    assign head   = mem[rd_ptr];
    assign opc    = head.inst[6:0];
    assign rd     = head.inst[11:7];
    assign funct3 = head.inst[14:12];
    assign rs1    = head.inst[19:15];
    assign rs2    = head.inst[24:20];

    assign imm_i = XLEN'($signed(head.inst[31:20]));
    assign imm_s = XLEN'($signed({head.inst[31:25], head.inst[11:7]}));
    assign imm_b = XLEN'($signed({head.inst[31], head.inst[7], head.inst[30:25],
                                  head.inst[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({head.inst[31], head.inst[19:12], head.inst[20],
                                  head.inst[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({head.inst[31:12], 12'b0}));
    assign imm_z = XLEN'(rs1);

    always_comb begin
        dec         = '0;
        dec.fmt     = FMT_UNK;
        dec.is_load = (opc == OPC_LOAD);
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                dec.fmt = FMT_U; dec.imm = imm_u; dec.rd_ena = 1'b1;
            end
            OPC_JAL: begin
                dec.fmt = FMT_J; dec.imm = imm_j; dec.rd_ena = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_IMM, OPC_IMM32: begin
                dec.fmt = FMT_I; dec.imm = imm_i; dec.rs1_ena = 1'b1; dec.rd_ena = 1'b1;
            end
            OPC_BRANCH: begin
                dec.fmt = FMT_B; dec.imm = imm_b; dec.rs1_ena = 1'b1; dec.rs2_ena = 1'b1;
            end
            OPC_STORE: begin
                dec.fmt = FMT_S; dec.imm = imm_s; dec.rs1_ena = 1'b1; dec.rs2_ena = 1'b1;
            end
            OPC_OP, OPC_OP32: begin
                dec.fmt = FMT_R; dec.rs1_ena = 1'b1; dec.rs2_ena = 1'b1; dec.rd_ena = 1'b1;
            end
            OPC_SYSTEM: begin
                // only CSR ops (funct3 != 0) write rd; ECALL/EBREAK do not
                dec.fmt = FMT_SYS; dec.imm = imm_z; dec.rd_ena = (funct3 != 3'd0);
            end
            default: dec.fmt = FMT_UNK;
        endcase
        if (rd == 5'd0) dec.rd_ena = 1'b0;
`ifdef ID_ILLEGAL_TRAP_EN
        dec.illegal = (dec.fmt == FMT_UNK);
`endif
    end

    // head waits one cycle behind a load in the slot whose rd it reads
    assign hazard = id_valid && id_is_load && (id_rd_addr != 5'd0) &&
                    ((dec.rs1_ena && (rs1 == id_rd_addr)) ||
                     (dec.rs2_ena && (rs2 == id_rd_addr)));

    assign if_ready = (iq_count < CNT_W'(DEPTH)) && !flush;
    assign push     = if_valid && if_ready;
    assign load     = (!id_valid || ex_ready) && (iq_count != '0) && !hazard && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            iq_count <= '0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            iq_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (load) rd_ptr <= rd_ptr + PTR_W'(1);
            iq_count <= iq_count + CNT_W'(push) - CNT_W'(load);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{pc: if_pc, inst: if_inst};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_valid    <= 1'b0;
            id_pc       <= '0;
            id_inst     <= '0;
            id_rs1_addr <= '0;
            id_rs2_addr <= '0;
            id_rd_addr  <= '0;
            id_rs1_ena  <= 1'b0;
            id_rs2_ena  <= 1'b0;
            id_rd_ena   <= 1'b0;
            id_is_load  <= 1'b0;
            id_fmt      <= '0;
            id_imm      <= '0;
            id_illegal  <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (load) begin
            id_valid    <= 1'b1;
            id_pc       <= head.pc;
            id_inst     <= head.inst;
            id_rs1_addr <= rs1;
            id_rs2_addr <= rs2;
            id_rd_addr  <= rd;
            id_rs1_ena  <= dec.rs1_ena;
            id_rs2_ena  <= dec.rs2_ena;
            id_rd_ena   <= dec.rd_ena;
            id_is_load  <= dec.is_load;
            id_fmt      <= dec.fmt;
            id_imm      <= dec.imm;
            id_illegal  <= dec.illegal;
        end else if (ex_ready) begin
            id_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_id_decode_queue.sv
// Bench for id_decode_queue: decode vector table, directed queue/hazard/flush/reset
// sequences, and a randomized run against a queue-based reference model.
module tb_id_decode_queue;
    localparam int XLEN  = 64;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef ID_ILLEGAL_TRAP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, if_valid, if_ready, flush, ex_ready, id_valid;
    logic [XLEN-1:0] if_pc, id_pc, id_imm;
    logic [31:0] if_inst, id_inst;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic id_rs1_ena, id_rs2_ena, id_rd_ena, id_is_load, id_illegal;
    logic [2:0] id_fmt;
    logic [CNT_W-1:0] iq_count;

    int checks = 0;
    int errors = 0;

    id_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_inst(if_inst), .flush(flush), .ex_ready(ex_ready), .id_valid(id_valid),
        .id_pc(id_pc), .id_inst(id_inst), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr), .id_rs1_ena(id_rs1_ena),
        .id_rs2_ena(id_rs2_ena), .id_rd_ena(id_rd_ena), .id_is_load(id_is_load),
        .id_fmt(id_fmt), .id_imm(id_imm), .id_illegal(id_illegal), .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        rs1e, rs2e, rde;
    } vec_t;

    typedef struct {
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        rs1e, rs2e, rde, ld, ill;
    } exp_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference decode: format from opcode, then fields from the format rules.
    function automatic exp_t ref_dec(logic [31:0] i);
        exp_t e;
        e = '{default: '0};
        case (i[6:0])
            7'h37, 7'h17:               e.fmt = 3'd4;
            7'h6F:                      e.fmt = 3'd5;
            7'h63:                      e.fmt = 3'd3;
            7'h23:                      e.fmt = 3'd2;
            7'h33, 7'h3B:               e.fmt = 3'd0;
            7'h73:                      e.fmt = 3'd6;
            7'h67, 7'h03, 7'h13, 7'h1B: e.fmt = 3'd1;
            default:                    e.fmt = 3'd7;
        endcase
        case (e.fmt)
            3'd1: e.imm = {{52{i[31]}}, i[31:20]};
            3'd2: e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
            3'd3: e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd4: e.imm = {{32{i[31]}}, i[31:12], 12'b0};
            3'd5: e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            3'd6: e.imm = 64'(i[19:15]);
            default: e.imm = '0;
        endcase
        e.rs1e = (e.fmt <= 3'd3);
        e.rs2e = (e.fmt == 3'd0) || (e.fmt == 3'd2) || (e.fmt == 3'd3);
        e.rde  = ((e.fmt == 3'd0) || (e.fmt == 3'd1) || (e.fmt == 3'd4) || (e.fmt == 3'd5) ||
                  ((e.fmt == 3'd6) && (i[14:12] != 3'd0))) && (i[11:7] != 5'd0);
        e.ld   = (i[6:0] == 7'h03);
        e.ill  = ILL_EN && (e.fmt == 3'd7);
        return e;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [4:0] rd, r1, r2;
        rd = 5'($urandom_range(0, 3));
        r1 = 5'($urandom_range(0, 3));
        r2 = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 8))
            0: return {12'($urandom), r1, 3'b000, rd, 7'h13};
            1: return {7'h00, r2, r1, 3'b000, rd, 7'h33};
            2: return {12'($urandom), r1, 3'b011, rd, 7'h03};
            3: return {7'($urandom), r2, r1, 3'b011, 5'($urandom), 7'h23};
            4: return {7'($urandom), r2, r1, 3'b000, 5'($urandom), 7'h63};
            5: return {20'($urandom), rd, 7'h37};
            6: return {20'($urandom), rd, 7'h6F};
            7: return {12'($urandom), 5'($urandom), 3'($urandom), rd, 7'h73};
            default: return $urandom;
        endcase
    endfunction

    task automatic drain();
        if_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // Push n addi instructions back to back with execute stalled.
    task automatic fill(int n, logic [63:0] base);
        ex_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            if_valid = 1'b1;
            if_pc    = base + 64'(4 * i);
            if_inst  = {12'd5, 5'd0, 3'b000, 5'(i + 1), 7'h13};
            @(negedge clk);
        end
        if_valid = 1'b0;
    endtask

    vec_t tbl[13];
    ent_t exp_q[$];

    initial begin
        exp_t e, s, h;
        logic pred, hz;
        logic [4:0] rdv;
        logic [63:0] pc_ctr;
        int nq;

        tbl[0]  = '{32'h00500093, 3'd1, 64'h5,                1, 0, 1};
        tbl[1]  = '{32'hFE000EE3, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1, 1, 0};
        tbl[2]  = '{32'h800000B7, 3'd4, 64'hFFFFFFFF80000000, 0, 0, 1};
        tbl[3]  = '{32'h00128333, 3'd0, 64'h0,                1, 1, 1};
        tbl[4]  = '{32'h00513423, 3'd2, 64'h8,                1, 1, 0};
        tbl[5]  = '{32'hFF9FF0EF, 3'd5, 64'hFFFFFFFFFFFFFFF8, 0, 0, 1};
        tbl[6]  = '{32'h00008067, 3'd1, 64'h0,                1, 0, 0};
        tbl[7]  = '{32'h300211F3, 3'd6, 64'h4,                0, 0, 1};
        tbl[8]  = '{32'h00000073, 3'd6, 64'h0,                0, 0, 0};
        tbl[9]  = '{32'h00000000, 3'd7, 64'h0,                0, 0, 0};
        tbl[10] = '{32'h00013283, 3'd1, 64'h0,                1, 0, 1};
        tbl[11] = '{32'hFFFFF117, 3'd4, 64'hFFFFFFFFFFFFF000, 0, 0, 1};
        tbl[12] = '{32'hFFF5051B, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1, 0, 1};

        rst = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; flush = 1'b0; ex_ready = 1'b0;
        #2;
        chk("rst_id_valid", id_valid, 0);
        chk("rst_iq_count", iq_count, 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_id_imm", id_imm, 0);
        chk("rst_id_fmt", id_fmt, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_if_ready", if_ready, 1);

        // decode table, one instruction at a time, checking N+2 latency too
        ex_ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if_valid = 1'b1; if_pc = 64'h3000 + 64'(4 * k); if_inst = tbl[k].inst;
            @(negedge clk);
            if_valid = 1'b0;
            chk($sformatf("tbl%0d_lat1", k), id_valid, 0);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", k), id_valid, 1);
            chk($sformatf("tbl%0d_pc", k), id_pc, 64'h3000 + 64'(4 * k));
            chk($sformatf("tbl%0d_inst", k), id_inst, tbl[k].inst);
            chk($sformatf("tbl%0d_fmt", k), id_fmt, tbl[k].fmt);
            chk($sformatf("tbl%0d_imm", k), id_imm, tbl[k].imm);
            chk($sformatf("tbl%0d_rs1e", k), id_rs1_ena, tbl[k].rs1e);
            chk($sformatf("tbl%0d_rs2e", k), id_rs2_ena, tbl[k].rs2e);
            chk($sformatf("tbl%0d_rde", k), id_rd_ena, tbl[k].rde);
            chk($sformatf("tbl%0d_ld", k), id_is_load, tbl[k].inst[6:0] == 7'h03);
            chk($sformatf("tbl%0d_ill", k), id_illegal, ILL_EN && (tbl[k].fmt == 3'd7));
            chk($sformatf("tbl%0d_rs1", k), id_rs1_addr, tbl[k].inst[19:15]);
            chk($sformatf("tbl%0d_rs2", k), id_rs2_addr, tbl[k].inst[24:20]);
            chk($sformatf("tbl%0d_rd", k), id_rd_addr, tbl[k].inst[11:7]);
        end
        drain();

        // fill, overfill, backpressure, then in-order drain
        fill(4, 64'h1000);
        chk("fill_count3", iq_count, 3);
        chk("fill_ready", if_ready, 1);
        chk("fill_slot_valid", id_valid, 1);
        if_valid = 1'b1; if_pc = 64'h1010; if_inst = 32'h00500293;
        @(negedge clk);
        chk("fill_count4", iq_count, 4);
        chk("fill_full_ready", if_ready, 0);
        if_pc = 64'h1014;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_pc", id_pc, 64'h1000);
            chk("bp_inst", id_inst, 32'h00500093);
            chk("bp_valid", id_valid, 1);
            chk("bp_count", iq_count, 4);
            chk("bp_ready", if_ready, 0);
        end
        if_valid = 1'b0; ex_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("drain_valid", id_valid, 1);
            chk("drain_pc", id_pc, 64'h1000 + 64'(4 * k));
        end
        @(negedge clk);
        chk("drain_empty_valid", id_valid, 0);
        chk("drain_empty_count", iq_count, 0);
        drain();

        // load-use bubble
        if_valid = 1'b1; if_pc = 64'h4000; if_inst = 32'h00013283;
        @(negedge clk);
        if_pc = 64'h4004; if_inst = 32'h00128333;
        @(negedge clk);
        if_valid = 1'b0;
        chk("lu_v0", id_valid, 1);
        chk("lu_ld", id_inst, 32'h00013283);
        @(negedge clk);
        chk("lu_bubble", id_valid, 0);
        @(negedge clk);
        chk("lu_v2", id_valid, 1);
        chk("lu_add", id_inst, 32'h00128333);
        drain();

        // load to x0 never interlocks
        if_valid = 1'b1; if_pc = 64'h4100; if_inst = 32'h00013003;
        @(negedge clk);
        if_pc = 64'h4104; if_inst = 32'h00100333;
        @(negedge clk);
        if_valid = 1'b0;
        chk("lu0_v0", id_valid, 1);
        @(negedge clk);
        chk("lu0_v1", id_valid, 1);
        chk("lu0_add", id_inst, 32'h00100333);
        drain();

        // flush with a simultaneous push
        fill(4, 64'h2000);
        chk("fl_pre_count", iq_count, 3);
        flush = 1'b1; if_valid = 1'b1; if_pc = 64'h2100; if_inst = 32'h00500093;
        #1;
        chk("fl_ready_low", if_ready, 0);
        @(negedge clk);
        flush = 1'b0; if_valid = 1'b0;
        chk("fl_count", iq_count, 0);
        chk("fl_valid", id_valid, 0);
        ex_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("fl_dropped_valid", id_valid, 0);
        chk("fl_dropped_count", iq_count, 0);

        // async reset mid-drain
        fill(4, 64'h5000);
        ex_ready = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", id_valid, 0);
        chk("arst_count", iq_count, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("arst_after_valid", id_valid, 0);

        // randomized run against the queue model
        pc_ctr = 64'h8000;
        pred   = 1'b0;
        for (int c = 0; c < 2030; c++) begin
            if (c < 2000) begin
                if_valid = ($urandom_range(0, 9) < 7);
                ex_ready = ($urandom_range(0, 9) < 7);
                flush    = ($urandom_range(0, 31) == 0);
            end else begin
                if_valid = 1'b0; ex_ready = 1'b1; flush = 1'b0;
            end
            if_pc   = pc_ctr;
            if_inst = gen_inst();
            #1;
            chk("rnd_id_valid", id_valid, pred);
            chk("rnd_occupancy", 64'(int'(iq_count) + int'(id_valid)), 64'(exp_q.size()));
            nq = exp_q.size() - int'(id_valid);
            chk("rnd_if_ready", if_ready, !flush && (nq < DEPTH));
            if (id_valid) begin
                chk("rnd_slot_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = ref_dec(exp_q[0].inst);
                    chk("rnd_pc", id_pc, exp_q[0].pc);
                    chk("rnd_inst", id_inst, exp_q[0].inst);
                    chk("rnd_fmt", id_fmt, e.fmt);
                    chk("rnd_imm", id_imm, e.imm);
                    chk("rnd_ena", {id_rs1_ena, id_rs2_ena, id_rd_ena}, {e.rs1e, e.rs2e, e.rde});
                    chk("rnd_ld_ill", {id_is_load, id_illegal}, {e.ld, e.ill});
                end
            end
            // expected slot state after this edge
            if (flush) pred = 1'b0;
            else if (id_valid && !ex_ready) pred = 1'b1;
            else if (nq > 0) begin
                hz = 1'b0;
                if (id_valid && exp_q.size() > 1) begin
                    s   = ref_dec(exp_q[0].inst);
                    h   = ref_dec(exp_q[1].inst);
                    rdv = exp_q[0].inst[11:7];
                    hz  = s.ld && (rdv != 5'd0) &&
                          ((h.rs1e && exp_q[1].inst[19:15] == rdv) ||
                           (h.rs2e && exp_q[1].inst[24:20] == rdv));
                end
                pred = !hz;
            end else pred = 1'b0;
            if (flush) exp_q.delete();
            else begin
                if (id_valid && ex_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (if_valid && if_ready) begin
                    exp_q.push_back('{pc: if_pc, inst: if_inst});
                    pc_ctr = pc_ctr + 64'd4;
                end
            end
            @(negedge clk);
        end
        chk("rnd_final_model_empty", 64'(exp_q.size()), 0);
        chk("rnd_final_count", iq_count, 0);
        chk("rnd_final_valid", id_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_decode_queue.md
Name: id_decode_queue

Overview:
Decode stage with buffering, placed between fetch and execute. A DEPTH-entry instruction queue is filled from fetch over a valid/ready handshake. The head entry is decoded into register addresses/enables, a sign-extended immediate and a format code, then registered into a single output slot with its own valid/ready handshake. A one-bubble load-use interlock and a pipeline flush are built in.

Parameters:
XLEN, 64, datapath/PC width; legal values 32 or 64.
DEPTH, 4, queue entries; power of two, ≥2.
CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
if_valid  in  1  fetch offers {if_pc, if_inst}.
if_ready  out  1  queue can accept.
if_pc  in  XLEN  fetch PC.
if_inst  in  32  fetch instruction.
flush  in  1  discard queue and output slot.
ex_ready  in  1  execute accepts output slot.
id_valid  out  1  output slot holds a decoded instruction.
id_pc  out  XLEN  PC of slot.
id_inst  out  32  raw instruction.
id_rs1_addr, id_rs2_addr, id_rd_addr  out  5 each  inst[19:15], [24:20], [11:7].
id_rs1_ena, id_rs2_ena, id_rd_ena  out  1 each  operand use / writeback.
id_is_load  out  1  opcode 0000011.
id_fmt  out  3  0=R,1=I,2=S,3=B,4=U,5=J,6=SYS,7=unknown.
id_imm  out  XLEN  immediate per format.
id_illegal  out  1  see Optional Feature.
iq_count  out  CNT_W  queue occupancy.

Behaviour:
- Reset (rst=0, async): queue pointers/count=0, id_valid=0, all id_* outputs 0, if_ready=1 after release.
- Queue: push when if_valid&if_ready; pop when the head moves to the slot. if_ready = (iq_count<DEPTH) & ~flush, registered-count based only (no combinational path from ex_ready). Pointers wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged. Full: no push. Empty: no pop.
- Slot load condition: load = (~id_valid | ex_ready) & (iq_count≠0) & ~hazard & ~flush. On load, decoded head fields are registered and id_valid=1 next cycle. If ex_ready & ~load, id_valid→0. Otherwise the slot holds (all outputs stable while id_valid & ~ex_ready).
- Latency: instruction pushed at cycle N appears with id_valid=1 at N+2 at the earliest (queue write, then slot register).
- Hazard: id_valid & id_is_load & id_rd_addr≠0 & head reads a register (rs1_ena & rs1==id_rd_addr, or rs2_ena & rs2==id_rd_addr). The load leaves on ex_ready. The slot goes empty for exactly one cycle (bubble) and the head stays. The next cycle the hazard is false.
- Enables: rs1_ena for I/S/B/R and JALR. rs2_ena for R/S/B. rd_ena for R/I/U/J/JALR/loads and CSR-with-rd≠0. Never enabled for S/B. x0 as rd gives rd_ena=0.
- Immediates: I={inst[31:20]}, S={[31:25],[11:7]}, B={[31],[7],[30:25],[11:8],0}, J={[31],[19:12],[20],[30:21],0}, all sign-extended to XLEN. U={[31:12],12'b0} sign-extended from bit 31. SYS: CSR zimm inst[19:15] zero-extended. R/unknown: 0.
- Flush: takes priority over everything that cycle. Next cycle count=0, pointers=0, id_valid=0. A same-cycle push is dropped. A flush during a hazard clears the hazard.
- Reset mid-operation clears everything regardless of handshake state.

Optional Feature:
ID_ILLEGAL_TRAP_EN: when defined, id_illegal=1 for inst[1:0]≠2'b11 or an opcode outside {LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP-IMM,OP-IMM-32,OP,OP-32,SYSTEM}. In that case all three enables are forced to 0, id_fmt=7 and id_imm=0, and the slot still flows normally. When undefined, id_illegal is tied 0 and unknown opcodes decode as fmt=7 with all enables 0.

Test Plan:
- Fill: push 4 instrs (addi x1,x0,5 = 0x00500093…) with ex_ready=0. Required: iq_count=3 and if_ready=1 while one instr is in the slot; after the 5th push, count=4 and if_ready=0. Then drain with ex_ready=1: one per cycle, in order.
- Load-use: ld x5,0(x2) then add x6,x5,x1, ex_ready=1 throughout. Required: id_valid sequence 1,0,1 (one bubble). With x0 as the load rd, no bubble.
- Immediates (XLEN=64): beq with offset -4 (0xFE000EE3) gives fmt=3, id_imm=0xFFFFFFFFFFFFFFFC. lui x1,0x80000 gives id_imm=0xFFFFFFFF80000000. For XLEN=32, the same lui gives 0x80000000.
- Backpressure: id_valid=1, ex_ready=0 for 5 cycles while pushing. Required: slot outputs stable, queue fills to DEPTH, if_ready=0.
- Flush: queue at 3, slot valid, flush=1 with if_valid=1. Required: next cycle count=0, id_valid=0, pushed instr dropped.
- Reset: assert rst=0 asynchronously mid-drain. Required: id_valid=0 and iq_count=0 immediately. With ID_ILLEGAL_TRAP_EN, 0x00000000 gives id_illegal=1 and all enables 0.
